// File: rtl/led_adder_dma_core.sv
// Read-and-accumulate engine: fetches cfg_len words from cfg_src_addr over a
// single-outstanding read interface, sums them and exposes sum, flags and LEDs.
module led_adder_dma_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int LED_WIDTH  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  cfg_start,
    input  logic                  cfg_clear,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data,
    input  logic                  rd_rsp_err,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_ovf,
    output logic                  sts_err,
    output logic [DATA_WIDTH-1:0] result,
    output logic [LED_WIDTH-1:0]  led
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP       = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE         = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH:0] add_with_carry(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LEN_WIDTH-1:0]    remaining_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   result_r;
    logic [LED_WIDTH-1:0]    led_r;
    logic                    done_r;
    logic                    ovf_r;
    logic                    err_r;
    logic                    req_valid_r;
    logic                    busy_r;
    logic                    start_accept_s;
    logic                    flag_clear_s;
    logic                    ovf_set_s;
    logic                    err_set_s;
    logic [DATA_WIDTH:0]     sum_s;

    assign sum_s = add_with_carry(result_r, data_r);

    // Next-state decode plus the one-cycle flag set/clear strobes.
    always_comb begin
        state_next_s   = state_r;
        start_accept_s = 1'b0;
        ovf_set_s      = 1'b0;
        err_set_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    start_accept_s = 1'b1;
                    if (cfg_len == '0) begin
                        state_next_s = ST_FIN;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_req_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rd_rsp_valid && rd_rsp_err) begin
                    err_set_s    = 1'b1;
                    state_next_s = ST_FIN;
                end else if (rd_rsp_valid) begin
                    state_next_s = ST_ACC;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACC: begin
                ovf_set_s = sum_s[DATA_WIDTH];
                if (remaining_r == LEN_ONE) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        flag_clear_s = cfg_clear | start_accept_s;
    end

    // State, datapath and output registers; request/busy follow the next state
    // so they are valid in the same cycle the FSM enters REQ / leaves IDLE.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            data_r      <= '0;
            result_r    <= '0;
            led_r       <= '0;
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_valid_r <= (state_next_s == ST_REQ);
            busy_r      <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start_accept_s) begin
                        addr_r      <= cfg_src_addr & ADDR_ALIGN_MASK;
                        remaining_r <= cfg_len;
                        result_r    <= '0;
                    end else begin
                        addr_r      <= addr_r;
                    end
                end
                ST_WAIT: begin
                    if (rd_rsp_valid && !rd_rsp_err) begin
                        data_r <= rd_rsp_data;
                    end else begin
                        data_r <= data_r;
                    end
                end
                ST_ACC: begin
                    result_r    <= sum_s[DATA_WIDTH-1:0];
                    addr_r      <= addr_r + ADDR_STEP;
                    remaining_r <= remaining_r - LEN_ONE;
                end
                ST_FIN: begin
                    led_r <= result_r[LED_WIDTH-1:0];
                end
                default: begin
                    led_r <= led_r;
                end
            endcase
        end
    end

    // Sticky status flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (state_r == ST_FIN) begin
                done_r <= 1'b1;
            end else if (flag_clear_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (flag_clear_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (flag_clear_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign rd_req_valid = req_valid_r;
    assign rd_req_addr  = addr_r;
    assign sts_busy     = busy_r;
    assign sts_done     = done_r;
    assign sts_ovf      = ovf_r;
    assign sts_err      = err_r;
    assign result       = result_r;
    assign led          = led_r;

endmodule
